// File: rtl/mps_boot_loader.sv
// mps_boot_loader: framed byte-stream loader for the MPS instruction memory.
// Frame: 0xA5 sync, word count N, N*B payload bytes (LSB first), XOR checksum.
// The CPU is held in reset while loading and released only on a good checksum.
//
// Handshake: a byte moves on a rising clock edge when in_valid && in_ready.
// in_valid/in_data are owned by the sender and must stay stable until the
// transfer edge; in_ready is 1 in every state after reset, so the loader
// never back-pressures and sustains one byte per cycle.
module mps_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_nreset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [2:0]            fsm_state
);

  localparam int B  = DATA_WIDTH / 8;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                state;
  logic [7:0]            len;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [BW-1:0]         byte_cnt;
  logic [7:0]            csum;
  // Lower B-1 byte lanes of the word being assembled; the top lane is taken
  // straight from in_data when the word completes.
  logic [DATA_WIDTH-9:0] word_buf;
  logic [IW-1:0]         idle_cnt;

  logic xfer;
  logic in_frame;
  logic timeout_hit;

  assign xfer        = in_valid && in_ready;
  assign in_frame    = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  // A transfer in the same cycle always beats the timeout.
  assign timeout_hit = in_frame && !xfer && (idle_cnt == IW'(TIMEOUT - 1));
  assign fsm_state   = state;

  // Idle counter: counts cycles without a transfer while inside a frame.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      idle_cnt <= '0;
    end else if (!in_frame || xfer || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Main loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      word_buf   <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_nreset <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      imem_we  <= 1'b0;
      if (timeout_hit) begin
        state      <= S_ERROR;
        cpu_nreset <= 1'b0;
        load_done  <= 1'b0;
        load_error <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (xfer && in_data == SYNC) state <= S_LEN;
          end
          S_LEN: begin
            if (xfer) begin
              len      <= in_data;
              word_idx <= '0;
              byte_cnt <= '0;
              csum     <= '0;
              state    <= (in_data == 8'd0) ? S_CSUM : S_DATA;
            end
          end
          S_DATA: begin
            if (xfer) begin
              csum <= csum ^ in_data;
              if (byte_cnt == BW'(B - 1)) begin
                imem_we    <= 1'b1;
                imem_waddr <= word_idx;
                imem_wdata <= {in_data, word_buf};
                word_idx   <= word_idx + 1'b1;
                byte_cnt   <= '0;
                if (word_idx == ADDR_WIDTH'(len - 8'd1)) state <= S_CSUM;
              end else begin
                for (int i = 0; i < B - 1; i++) begin
                  if (byte_cnt == BW'(i)) word_buf[8*i +: 8] <= in_data;
                end
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
          S_CSUM: begin
            if (xfer) begin
              if (in_data == csum) begin
                state      <= S_RUN;
                cpu_nreset <= 1'b1;
                load_done  <= 1'b1;
              end else begin
                state      <= S_ERROR;
                load_error <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (xfer && in_data == SYNC) begin
              state      <= S_LEN;
              cpu_nreset <= 1'b0;
              load_done  <= 1'b0;
            end
          end
          S_ERROR: begin
            if (xfer && in_data == SYNC) begin
              state      <= S_LEN;
              load_error <= 1'b0;
            end
          end
          default: begin
            state      <= S_IDLE;
            cpu_nreset <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
